freq_meter: RTL

- Measures the frequency of an external digital signal against a fixed gate window derived from the system clock.
- The window is GATE_CYCLES system clocks long; 50,000,000 at 50 MHz gives a 1 s window, so the result is in Hz.
- Rising edges of the input are counted in packed BCD for direct use by the 7-segment display path.
- The result register updates once per window, and a one-cycle valid strobe marks each update.

---
 rtl/freq_meter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// Gate-window frequency meter: counts synchronized rising edges of sig_in in packed BCD
// over GATE_CYCLES clocks and publishes the count with a one-cycle valid strobe.
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int DIGITS      = 4
) (
    input  logic                  clk_50mhz,
    input  logic                  reset,
    input  logic                  sig_in,
    input  logic                  enable,
    output logic [4*DIGITS-1:0]   freq_bcd,
    output logic                  overflow,
    output logic                  valid,
    output logic                  gate_active
);
    localparam int BW = 4 * DIGITS;
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0] GATE_ONE  = GW'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GATE = 1'b1
    } state_t;

    function automatic logic all_nines(input logic [BW-1:0] v);
        logic r;
        r = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            r = r & (v[4*d +: 4] == 4'd9);
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = carry ? ((v[4*d +: 4] == 4'd9) ? 4'd0 : (v[4*d +: 4] + 4'd1))
                                : v[4*d +: 4];
            carry       = carry & (v[4*d +: 4] == 4'd9);
        end
        return r;
    endfunction

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic [GW-1:0]   r_gate_cnt;
    logic [BW-1:0]   r_count;
    logic            r_sat;
    logic [BW-1:0]   r_freq;
    logic            r_ovf;
    logic            r_valid;
    logic            r_gate_active;

    logic            w_rise;
    logic            w_win_end;
    logic [BW-1:0]   w_count_next;
    logic            w_sat_next;

    assign w_rise    = r_sync2 & ~r_prev;
    assign w_win_end = (r_gate_cnt == {GW{1'b0}});

    // Two-flop synchronizer for the asynchronous input plus the edge-detect history flop
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Saturating BCD count including this cycle's edge; all-9s holds and raises the flag
    always_comb begin
        w_count_next = r_count;
        w_sat_next   = r_sat;
        if (w_rise) begin
            if (all_nines(r_count)) begin
                w_sat_next = 1'b1;
            end else begin
                w_count_next = bcd_inc(r_count);
            end
        end else begin
            w_count_next = r_count;
        end
    end

    // Gate FSM; enable dropping on the window-end cycle still publishes that window
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_gate_cnt    <= GATE_LOAD;
            r_count       <= {BW{1'b0}};
            r_sat         <= 1'b0;
            r_freq        <= {BW{1'b0}};
            r_ovf         <= 1'b0;
            r_valid       <= 1'b0;
            r_gate_active <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_count    <= {BW{1'b0}};
                    r_sat      <= 1'b0;
                    r_gate_cnt <= GATE_LOAD;
                    if (enable) begin
                        r_state       <= S_GATE;
                        r_gate_active <= 1'b1;
                    end else begin
                        r_state       <= S_IDLE;
                        r_gate_active <= 1'b0;
                    end
                end
                S_GATE: begin
                    if (w_win_end) begin
                        r_freq     <= w_count_next;
                        r_ovf      <= w_sat_next;
                        r_valid    <= 1'b1;
                        r_count    <= {BW{1'b0}};
                        r_sat      <= 1'b0;
                        r_gate_cnt <= GATE_LOAD;
                    end else if (!enable) begin
                        r_count    <= {BW{1'b0}};
                        r_sat      <= 1'b0;
                        r_gate_cnt <= GATE_LOAD;
                    end else begin
                        r_count    <= w_count_next;
                        r_sat      <= w_sat_next;
                        r_gate_cnt <= r_gate_cnt - GATE_ONE;
                    end
                    if (enable) begin
                        r_state       <= S_GATE;
                        r_gate_active <= 1'b1;
                    end else begin
                        r_state       <= S_IDLE;
                        r_gate_active <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_gate_active <= 1'b0;
                end
            endcase
        end
    end

    assign freq_bcd    = r_freq;
    assign overflow    = r_ovf;
    assign valid       = r_valid;
    assign gate_active = r_gate_active;

endmodule
